// File: rtl/obstacle_controller.sv
// rtl/obstacle_controller.sv - obstacle spawn/move/despawn producer for the collision checker
//
// obstacle_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4), shifts left every clock.
//   clock, reset : clock and synchronous active-high reset (reloads SEED)
//   upper        : bits [7:4] of the register (random gap extension)
//   lsb          : bit [0] of the register (obstacle type select)
//
// obstacle_controller: spawns, moves and despawns the single on-screen obstacle.
//   clock, reset : clock and synchronous active-high reset
//   start        : pulse, begins play from IDLE or restarts from CRASH
//   frameTick    : pulse once per display frame
//   collision    : hit flag returned by the collision checker
//   obstacleX/Y  : obstacle position to checker/renderer
//   obstacleId   : 0 = ground, 1 = flying
//   checkUpdate  : one-cycle update pulse to the checker after each move
//   active       : obstacle on screen
//   gameOver     : high while crashed
//   score        : obstacles cleared, saturating

module obstacle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] upper,
  output logic       lsb
);

  logic [7:0] value;
  logic       feedback;

  // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
  assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];
  assign upper    = value[7:4];
  assign lsb      = value[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {value[6:0], feedback};
    end
  end

endmodule

module obstacle_controller #(
  parameter logic [7:0] X_GROUND      = 8'd40,
  parameter logic [7:0] X_AIR         = 8'd100,
  parameter logic [8:0] Y_SPAWN       = 9'd320,
  parameter int         SPEED_INIT    = 4,
  parameter int         SPEED_MAX     = 12,
  parameter int         SPEEDUP_EVERY = 5,
  parameter int         GAP_MIN       = 20,
  parameter int         SAMPLE_DELAY  = 2,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frameTick,
  input  logic       collision,
  output logic [7:0] obstacleX,
  output logic [8:0] obstacleY,
  output logic [3:0] obstacleId,
  output logic       checkUpdate,
  output logic       active,
  output logic       gameOver,
  output logic [9:0] score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_SPAWN = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_CRASH = 3'd5;

  localparam logic [3:0] SPEED_INIT_W   = 4'(SPEED_INIT);
  localparam logic [3:0] SPEED_MAX_W    = 4'(SPEED_MAX);
  localparam logic [7:0] SPEEDUP_LAST   = 8'(SPEEDUP_EVERY - 1);
  localparam logic [7:0] GAP_MIN_W      = 8'(GAP_MIN);
  // CHECK is entered on the edge that raises checkUpdate; the sample edge is
  // SAMPLE_DELAY edges later, so the counter stops one short of the delay.
  localparam logic [3:0] SAMPLE_LAST    = 4'(SAMPLE_DELAY - 1);
  localparam logic [9:0] SCORE_MAX      = 10'h3FF;

  logic [2:0] state;
  logic [3:0] speed;
  logic [7:0] gap_count;
  logic [7:0] speedup_count;
  logic [3:0] sample_count;
  logic [3:0] lfsr_upper;
  logic       lfsr_lsb;
  logic [8:0] speed_ext;

  assign speed_ext = {5'd0, speed};

  obstacle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .upper (lfsr_upper),
    .lsb   (lfsr_lsb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      obstacleX     <= X_GROUND;
      obstacleY     <= Y_SPAWN;
      obstacleId    <= 4'd0;
      checkUpdate   <= 1'b0;
      active        <= 1'b0;
      gameOver      <= 1'b0;
      score         <= 10'd0;
      speed         <= SPEED_INIT_W;
      gap_count     <= 8'd0;
      speedup_count <= 8'd0;
      sample_count  <= 4'd0;
    end else begin
      // checkUpdate is a pulse; only the MOVE->CHECK transition raises it.
      checkUpdate <= 1'b0;

      case (state)
        S_IDLE: begin
          // A frameTick coinciding with start is simply not consumed here.
          if (start) begin
            gap_count <= GAP_MIN_W;
            state     <= S_GAP;
          end
        end

        S_GAP: begin
          active <= 1'b0;
          if (frameTick) begin
            if (gap_count == 8'd0) begin
              state <= S_SPAWN;
            end else begin
              gap_count <= gap_count - 8'd1;
            end
          end
        end

        S_SPAWN: begin
          obstacleId <= {3'd0, lfsr_lsb};
          obstacleX  <= lfsr_lsb ? X_AIR : X_GROUND;
          obstacleY  <= Y_SPAWN;
          active     <= 1'b1;
          state      <= S_MOVE;
        end

        S_MOVE: begin
          if (frameTick) begin
            if (obstacleY < speed_ext) begin
              // Obstacle has left the screen: count it and schedule the next.
              active <= 1'b0;
              if (score != SCORE_MAX) begin
                score <= score + 10'd1;
              end
              if (speedup_count == SPEEDUP_LAST) begin
                speedup_count <= 8'd0;
                speed         <= (speed < SPEED_MAX_W) ? speed + 4'd1 : SPEED_MAX_W;
              end else begin
                speedup_count <= speedup_count + 8'd1;
              end
              gap_count <= GAP_MIN_W + {4'd0, lfsr_upper};
              state     <= S_GAP;
            end else begin
              obstacleY    <= obstacleY - speed_ext;
              checkUpdate  <= 1'b1;
              sample_count <= 4'd0;
              state        <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (sample_count == SAMPLE_LAST) begin
            if (collision) begin
              gameOver <= 1'b1;
              state    <= S_CRASH;
            end else begin
              state <= S_MOVE;
            end
          end else begin
            sample_count <= sample_count + 4'd1;
          end
        end

        S_CRASH: begin
          // Position, id and active stay frozen so the renderer shows the hit.
          if (start) begin
            gameOver      <= 1'b0;
            score         <= 10'd0;
            speed         <= SPEED_INIT_W;
            speedup_count <= 8'd0;
            active        <= 1'b0;
            gap_count     <= GAP_MIN_W;
            state         <= S_GAP;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
